// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between the two lane FIFOs, the round-robin scheduler
// and the downstream consumer.
//   dataIn0/1, validIn0/1 : head-of-FIFO word and non-empty flag per lane
//   ready                 : downstream can accept a word this cycle
//   pop0/1                : lane head consumed at the coming edge
//   selector              : 2:1 mux select (1 = lane 1)
//   dataOut, validOut     : registered output stream
// modport master : scheduler side; modport slave : FIFO/consumer side.
interface mux_rr_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] dataIn0;
  logic [WIDTH-1:0] dataIn1;
  logic             validIn0;
  logic             validIn1;
  logic             ready;
  logic             pop0;
  logic             pop1;
  logic             selector;
  logic [WIDTH-1:0] dataOut;
  logic             validOut;

  modport master (
    input  dataIn0, dataIn1, validIn0, validIn1, ready,
    output pop0, pop1, selector, dataOut, validOut
  );

  modport slave (
    output dataIn0, dataIn1, validIn0, validIn1, ready,
    input  pop0, pop1, selector, dataOut, validOut
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 2:1 data mux and output register
// between two upstream FIFO lanes. A granted lane keeps the grant for up to
// BURST words, then hands over to the other lane if it has data.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : mux_rr_scheduler_if.master (lane inputs, ready, pops, selector,
//           registered dataOut/validOut)
// Parameters: WIDTH data width, BURST words per grant (1..15).
module mux_rr_scheduler #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mux_rr_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_e;

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  logic             lane;
  logic             v_cur;
  logic             v_oth;
  logic [WIDTH-1:0] d_cur;
  logic             xfer;
  logic             done;
  logic             pop0;
  logic             pop1;

  // Index of the granted lane; only meaningful in a GRANT state.
  assign lane = (state_q == GRANT1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = 1'b0;
    v_cur   = 1'b0;
    v_oth   = 1'b0;
    d_cur   = '0;
    xfer    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie the lane that was not served last wins.
        if (bus.validIn0 && (!bus.validIn1 || last_q)) begin
          state_d = GRANT0;
        end else if (bus.validIn1) begin
          state_d = GRANT1;
        end
      end

      GRANT0, GRANT1: begin
        v_cur = lane ? bus.validIn1 : bus.validIn0;
        v_oth = lane ? bus.validIn0 : bus.validIn1;
        d_cur = lane ? bus.dataIn1  : bus.dataIn0;
        xfer  = v_cur && bus.ready;

        if (xfer) begin
          data_d  = d_cur;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
        end

        // Stalled by ready with data pending is not an exit: the grant holds.
        done = !v_cur || (xfer && (cnt_q == BURST_LAST));

        if (done) begin
          if (v_oth) begin
            state_d = lane ? GRANT0 : GRANT1;
            cnt_d   = '0;
            last_d  = lane;
          end else if (v_cur) begin
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            last_d  = lane;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pop0 = xfer && !lane && !reset;
    pop1 = xfer &&  lane && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pop0     = pop0;
  assign bus.pop1     = pop1;
  assign bus.selector = (state_q == GRANT1);
  assign bus.dataOut  = data_q;
  assign bus.validOut = valid_q;

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the 2:1 data mux and its output register between two upstream lanes. It pops words from two upstream FIFOs (lane 0, lane 1) and drives the mux `selector`. Each lane keeps the grant for a bounded burst, and the scheduler registers the selected word onto a single 8-bit output stream. It sits between the per-lane FIFOs and the downstream consumer, and applies downstream back-pressure through `ready`.

## Interface
- `WIDTH`, 8: data width of each lane and of the output.
- `BURST`, 4: maximum words transferred per grant. Legal range is 1..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dataIn0`  in  WIDTH  lane 0 head-of-FIFO word.
- `dataIn1`  in  WIDTH  lane 1 head-of-FIFO word.
- `validIn0`  in  1  lane 0 FIFO non-empty (head word valid).
- `validIn1`  in  1  lane 1 FIFO non-empty.
- `ready`  in  1  downstream can accept a word this cycle.
- `pop0`  out  1  combinational; lane 0 head consumed at this edge.
- `pop1`  out  1  combinational; lane 1 head consumed at this edge.
- `selector`  out  1  mux select; 1 only in GRANT1, else 0.
- `dataOut`  out  WIDTH  registered output word.
- `validOut`  out  1  registered; `dataOut` carries a new word this cycle.

## Operation
- **Reset values:** state IDLE, `dataOut` = 0, `validOut` = 0, burst counter `cnt` = 0, `last` = 1 so lane 0 wins first. `pop0`/`pop1` are forced 0 while `reset` = 1.
- **States:** IDLE, GRANT0, GRANT1.
- **IDLE:**
  - If `validIn0` && (!`validIn1` || `last` = 1), go to GRANT0.
  - Else if `validIn1`, go to GRANT1.
  - Else stay in IDLE.
  - `cnt` <= 0. No transfer occurs in IDLE.
- **GRANTi transfer condition:** `xfer` = `validIni` && `ready`.
  - `popi` = `xfer`.
  - At the edge: `dataOut` <= `dataIni`, `validOut` <= 1, `cnt` <= `cnt`+1.
- **No transfer:** `validOut` <= 0 and `dataOut` holds its value.
- **GRANTi exit condition:** `done` = !`validIni` || (`xfer` && `cnt` = BURST-1).
- **When `done`:**
  - If the other lane is valid, go to GRANT(other), `cnt` <= 0, `last` <= i.
  - Else if `validIni` (burst limit hit, no contender), stay in GRANTi with `cnt` <= 0.
  - Else go to IDLE with `last` <= i.
- **Back-pressure:** `ready` = 0 with `validIni` = 1 holds the state, `cnt`, and `dataOut`. The grant is not lost.
- `pop0` and `pop1` are never asserted in the same cycle.
- Counter width is 4 bits. `cnt` never exceeds BURST-1.

## Timing
- **Arbitration latency:** request sampled in IDLE at edge n, grant state at n+1, `pop` and `xfer` during cycle n+1, `validOut` high after edge n+2.
- **Throughput:** a granted lane with `ready` = 1 produces one word per cycle.
- **Lane switch at burst end** costs 0 idle cycles. The first word of the new lane transfers in the cycle right after the last word of the old lane.
- **Switch caused by `validIni` dropping** costs 1 cycle: no transfer in that cycle.
- **Simultaneous first requests from IDLE:** the lane ≠ `last` wins.
- **Reset asserted mid-burst:** at the next edge, everything returns to reset values, with no `pop` in the reset cycle. Any in-flight `dataOut` is cleared to 0.
- **BURST = 1:** grants strictly alternate word by word while both lanes are valid.

## Test plan
- **Reset then single lane:** `validIn0` = 1 held, `dataIn0` = 8'h11, 8'h12, … with `ready` = 1 → state GRANT0 one cycle after reset release, `pop0` every cycle, `validOut` words 11, 12, … starting two cycles after the request. `selector` = 0 and `pop1` = 0 throughout.
- **Both lanes continuously valid, BURST = 4:** output order is 4 lane-0 words, 4 lane-1 words, 4 lane-0 words. There is no bubble at each switch, and `selector` toggles every 4 transfers.
- **Back-pressure:** during GRANT1 after 2 transfers, drop `ready` for 3 cycles → `pop1` = 0, `validOut` = 0, and `dataOut` held for those cycles. When `ready` returns, exactly 2 more lane-1 words transfer before the switch.
- **Lane drains early:** lane 0 supplies 2 words then `validIn0` = 0, with `validIn1` = 1 → one idle cycle, then GRANT1. `last` = 0, so the next simultaneous request from IDLE goes to lane 1.
- **Reset mid-burst:** assert `reset` during GRANT0 with `cnt` = 2 → next cycle `dataOut` = 8'h00, `validOut` = 0, state IDLE. With both lanes valid afterwards, lane 0 wins first.
- **BURST = 1, both lanes valid:** output alternates lane 0, lane 1, lane 0, … every cycle, and `pop0`/`pop1` are never high together.
